punc_mem_arbiter: RTL and testbench

- Arbitrates the single-ported PUnC unified memory between three requesters: instruction fetch (index 0), data load/store (index 1) and the debug/loader port (index 2).
- Sits between PUnC control/datapath and the memory array, and sequences every memory access through one grant/issue/response FSM.
- Supports one outstanding access at a time, with a fixed read latency.

---
 rtl/punc_mem_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_punc_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// punc_mem_arbiter
//
// Shares the single-ported PUnC unified memory between three requesters:
//   index 0 = instruction fetch, index 1 = data load/store, index 2 = debug.
// One access is in flight at a time. A single IDLE/GRANT/WAIT/RESP FSM
// sequences every access: the winner is registered on entry to GRANT, reads
// spend RD_LAT cycles in WAIT, and RESP returns the data while arbitrating
// again so a new GRANT can follow back to back.
//
// Default arbitration is fixed priority data > fetch > debug, except that
// debug is promoted to the top once it has waited MAX_WAIT cycles.
// Build option PUNC_ARB_RR_EN replaces this with round-robin 0 -> 1 -> 2.
//
// Parameters:
//   RD_LAT    memory read latency, mem_en to valid mem_rdata (1..4)
//   MAX_WAIT  debug wait cycles before promotion (1..15)
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   req/we[2:0]         per-requester request and write enable
//   addr/wdata[47:0]    per-requester 16-bit fields, requester i at [16i+:16]
//   gnt[2:0]            one-hot grant pulse (GRANT cycle)
//   rvalid[2:0]         one-hot read-data-valid pulse (RESP cycle)
//   rdata[15:0]         captured read data, holds between responses
//   busy                high in GRANT and WAIT
//   mem_en/mem_we       memory strobes, only in GRANT
//   mem_addr/mem_wdata  registered access fields, hold outside GRANT
//   mem_rdata           memory read data, valid RD_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module punc_mem_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [47:0] addr,
    input  logic [47:0] wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index of the last WAIT cycle; mem_rdata is valid during it.
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic        arb_take;
    logic [1:0]  win_idx;
    logic        win_we;
    logic [15:0] win_addr, win_wdata;
    logic [1:0]  sel_idx;
    logic        sel_we;
    logic [15:0] sel_addr, sel_wdata;
    logic [2:0]  lat_cnt;
    logic        lat_done;

`ifdef PUNC_ARB_RR_EN
    logic [1:0]  rr_ptr;
`else
    localparam logic [3:0] MAX_WAIT_Q = 4'(MAX_WAIT);
    logic [3:0]  wait_cnt;
`endif

    // ------------------------------------------------------------------
    // Winner selection from the current req vector. Only consumed when
    // the FSM is at an arbitration point (IDLE or RESP) with any req high.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        win_idx = 2'd0;
`ifdef PUNC_ARB_RR_EN
        // Search starts just after the last-granted index.
        case (rr_ptr)
            2'd0: begin
                if      (req[1]) win_idx = 2'd1;
                else if (req[2]) win_idx = 2'd2;
                else if (req[0]) win_idx = 2'd0;
            end
            2'd1: begin
                if      (req[2]) win_idx = 2'd2;
                else if (req[0]) win_idx = 2'd0;
                else if (req[1]) win_idx = 2'd1;
            end
            default: begin
                if      (req[0]) win_idx = 2'd0;
                else if (req[1]) win_idx = 2'd1;
                else if (req[2]) win_idx = 2'd2;
            end
        endcase
`else
        // Starved debug jumps the queue; otherwise data > fetch > debug.
        if      (req[2] && (wait_cnt >= MAX_WAIT_Q)) win_idx = 2'd2;
        else if (req[1])                             win_idx = 2'd1;
        else if (req[0])                             win_idx = 2'd0;
        else if (req[2])                             win_idx = 2'd2;
`endif
    end

    // Unpack the winner's access fields.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        case (win_idx)
            2'd0: begin
                win_we    = we[0];
                win_addr  = addr[15:0];
                win_wdata = wdata[15:0];
            end
            2'd1: begin
                win_we    = we[1];
                win_addr  = addr[31:16];
                win_wdata = wdata[31:16];
            end
            default: begin
                win_we    = we[2];
                win_addr  = addr[47:32];
                win_wdata = wdata[47:32];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state and outputs
    always_comb begin
        state_nxt = state;
        arb_take  = 1'b0;
        lat_done  = (lat_cnt == LAT_LAST);
        gnt       = '0;
        rvalid    = '0;
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    arb_take  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                gnt       = 3'b001 << sel_idx;
                mem_en    = 1'b1;
                mem_we    = sel_we;
                busy      = 1'b1;
                // A write completes in its GRANT cycle.
                state_nxt = sel_we ? IDLE : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (lat_done) state_nxt = RESP;
            end
            RESP: begin
                rvalid = 3'b001 << sel_idx;
                if (|req) begin
                    arb_take  = 1'b1;
                    state_nxt = GRANT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    // ------------------------------------------------------------------
    // Registered access fields, read latency counter and read data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the access fields and rdata drive outputs directly, so they
        // are reset too; that is what makes every output read 0 in reset.
        if (!rst) begin
            sel_idx   <= 2'd0;
            sel_we    <= 1'b0;
            sel_addr  <= '0;
            sel_wdata <= '0;
            lat_cnt   <= '0;
            rdata     <= '0;
        end else begin
            if (arb_take) begin
                sel_idx   <= win_idx;
                sel_we    <= win_we;
                sel_addr  <= win_addr;
                sel_wdata <= win_wdata;
            end
            if (state == GRANT)
                lat_cnt <= '0;
            else if ((state == WAIT) && !lat_done)
                lat_cnt <= lat_cnt + 3'd1;
            if ((state == WAIT) && lat_done)
                rdata <= mem_rdata;
        end
    end

`ifdef PUNC_ARB_RR_EN
    // Pointer starts at 2 so fetch (index 0) wins the first round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                rr_ptr <= 2'd2;
        else if (state == GRANT) rr_ptr <= sel_idx;
    end
`else
    // Counts consecutive cycles debug is requesting without a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      wait_cnt <= '0;
        else if (!req[2] || gnt[2])    wait_cnt <= '0;
        else if (wait_cnt != 4'hF)     wait_cnt <= wait_cnt + 4'd1;
    end
`endif

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_punc_mem_arbiter
//
// Drives punc_mem_arbiter (RD_LAT=3, MAX_WAIT=8) through directed scenarios
// and a randomized phase. A transaction-level reference model decides each
// arbitration from the request rules and schedules the resulting grant,
// busy window and read response by cycle number; a behavioural memory
// answers the DUT's mem_* strobes. Every output is compared every cycle.
// Build with PUNC_ARB_RR_EN to check the round-robin variant.
// ---------------------------------------------------------------------------
module tb_punc_mem_arbiter;

    localparam int RD_LAT   = 3;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [47:0] addr = '0;
    logic [47:0] wdata = '0;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    always #5 clk = ~clk;

    punc_mem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp_v);
        end
    endtask

    // ---------------- requester stimulus (staged, applied after posedge)
    logic [2:0]  s_req = '0;
    logic [2:0]  s_we = '0;
    logic [15:0] s_addr[3];
    logic [15:0] s_wdata[3];
    logic [2:0]  sticky = '0;
    bit          rand_mode = 1'b0;

    // ---------------- behavioural memory
    logic [15:0] dmem[int];
    logic [15:0] rd_sched[int];

    // ---------------- reference model
    typedef struct packed {
        logic [1:0]  idx;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
    } acc_t;
    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] d;
    } rsp_t;

    acc_t        gnt_rec[int];
    rsp_t        rsp_rec[int];
    logic [15:0] mmem[int];
    int          next_arb, busy_lo, busy_hi, m_cnt;
    logic [1:0]  m_last;
    logic [15:0] m_addr, m_wdata, m_rdata;
    int          first_g2;

    function automatic logic [15:0] fill(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [1:0] pick(input logic [2:0] r);
        logic [1:0] w;
        w = 2'd0;
`ifdef PUNC_ARB_RR_EN
        for (int k = 3; k >= 1; k--) begin
            int j;
            j = (int'(m_last) + k) % 3;
            if (r[j]) w = 2'(j);
        end
`else
        if      (r[2] && m_cnt >= MAX_WAIT) w = 2'd2;
        else if (r[1])                      w = 2'd1;
        else if (r[0])                      w = 2'd0;
        else                                w = 2'd2;
`endif
        return w;
    endfunction

    task automatic model_reset();
        gnt_rec.delete();
        rsp_rec.delete();
        rd_sched.delete();
        next_arb = cyc + 1;
        busy_lo  = -1;
        busy_hi  = -2;
        m_cnt    = 0;
        m_last   = 2'd2;
        m_addr   = '0;
        m_wdata  = '0;
        m_rdata  = '0;
    endtask

    task automatic post(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
        s_req[i]   = 1'b1;
        s_we[i]    = w;
        s_addr[i]  = a;
        s_wdata[i] = d;
    endtask

    task automatic drive_phase();
        @(posedge clk);
        cyc++;
        #1;
        req = s_req;
        we  = s_we;
        for (int i = 0; i < 3; i++) begin
            addr[16*i +: 16]  = s_addr[i];
            wdata[16*i +: 16] = s_wdata[i];
        end
        mem_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : 16'($urandom);
    endtask

    task automatic eval_phase();
        logic [2:0]  eg, ev;
        acc_t        g;
        logic [1:0]  w;
        logic [15:0] a, d;
        @(negedge clk);
        eg = '0;
        ev = '0;
        g  = '0;
        if (gnt_rec.exists(cyc)) begin
            g       = gnt_rec[cyc];
            eg      = 3'b001 << g.idx;
            m_addr  = g.a;
            m_wdata = g.d;
        end
        if (rsp_rec.exists(cyc)) begin
            ev      = 3'b001 << rsp_rec[cyc].idx;
            m_rdata = rsp_rec[cyc].d;
        end
        check("gnt",       16'(gnt),    16'(eg));
        check("rvalid",    16'(rvalid), 16'(ev));
        check("rdata",     rdata,       m_rdata);
        check("busy",      16'(busy),   16'(cyc >= busy_lo && cyc <= busy_hi));
        check("mem_en",    16'(mem_en), 16'(eg != 0));
        check("mem_we",    16'(mem_we), 16'(eg != 0 && g.wr));
        check("mem_addr",  mem_addr,    m_addr);
        check("mem_wdata", mem_wdata,   m_wdata);
        if (gnt[2] && first_g2 < 0) first_g2 = cyc;

        // memory answers whatever the DUT actually presented
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] = mem_wdata;
            else rd_sched[cyc + RD_LAT] = dmem.exists(mem_addr) ? dmem[mem_addr] : fill(mem_addr);
        end

        // model: one access at a time, next arbitration after it finishes
        if (eg != 0) m_last = g.idx;
        if (cyc == next_arb) begin
            if (req != 0) begin
                w = pick(req);
                a = addr[16*w +: 16];
                d = wdata[16*w +: 16];
                gnt_rec[cyc + 1] = '{idx: w, wr: we[w], a: a, d: d};
                busy_lo = cyc + 1;
                if (we[w]) begin
                    mmem[a]  = d;
                    busy_hi  = cyc + 1;
                    next_arb = cyc + 2;
                end else begin
                    rsp_rec[cyc + RD_LAT + 2] = '{idx: w, d: (mmem.exists(a) ? mmem[a] : fill(a))};
                    busy_hi  = cyc + 1 + RD_LAT;
                    next_arb = cyc + RD_LAT + 2;
                end
            end else begin
                next_arb = cyc + 1;
            end
        end
        m_cnt = (req[2] && !eg[2]) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;

        // requesters: drop (or renew) a request the cycle after its grant
        for (int i = 0; i < 3; i++) begin
            if (eg[i]) begin
                if (sticky[i]) s_wdata[i] = 16'($urandom);
                else           s_req[i]   = 1'b0;
            end
            if (rand_mode && !s_req[i] && $urandom_range(0, 3) == 0)
                post(i, 1'($urandom_range(0, 1)), 16'h3000 + 16'($urandom_range(0, 15)), 16'($urandom));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive_phase();
            eval_phase();
        end
    endtask

    task automatic check_zero(input string where);
        check({where, ".gnt"},       16'(gnt),    16'h0);
        check({where, ".rvalid"},    16'(rvalid), 16'h0);
        check({where, ".rdata"},     rdata,       16'h0);
        check({where, ".busy"},      16'(busy),   16'h0);
        check({where, ".mem_en"},    16'(mem_en), 16'h0);
        check({where, ".mem_we"},    16'(mem_we), 16'h0);
        check({where, ".mem_addr"},  mem_addr,    16'h0);
        check({where, ".mem_wdata"}, mem_wdata,   16'h0);
    endtask

    // Called right after an eval_phase; asserts reset mid-cycle.
    task automatic reset_mid();
        #2 rst = 1'b0;
        #1 check_zero("rst_mid");
        model_reset();
        s_req  = '0;
        sticky = '0;
        drive_phase();
        #2 rst = 1'b1;
        eval_phase();
    endtask

    int start;

    initial begin
        for (int i = 0; i < 3; i++) begin
            s_addr[i]  = '0;
            s_wdata[i] = '0;
        end
        first_g2 = -1;
        model_reset();
        #2 check_zero("reset");
        #10 rst = 1'b1;
        model_reset();

        // fetch read of a known word
        dmem[16'h3000] = 16'h1234;
        mmem[16'h3000] = 16'h1234;
        run(2);
        post(0, 1'b0, 16'h3000, 16'h0);
        run(8);

        // data write
        post(1, 1'b1, 16'h0010, 16'hBEEF);
        run(4);

        // contention, both reads: data first, fetch right after RESP
        post(0, 1'b0, 16'h3000, 16'h1111);
        post(1, 1'b0, 16'h0010, 16'h2222);
        run(14);

        // all three writing continuously
        first_g2 = -1;
        sticky   = 3'b111;
        post(0, 1'b1, 16'h3001, 16'hA000);
        post(1, 1'b1, 16'h3002, 16'hB000);
        post(2, 1'b1, 16'h3003, 16'hC000);
        start = cyc + 1;
        run(30);
`ifndef PUNC_ARB_RR_EN
        check("starve_g2_cycle", 16'(first_g2 - start), 16'(MAX_WAIT + 1));
`endif
        sticky = '0;
        run(12);

        // reset in the middle of a read's WAIT window
        post(0, 1'b0, 16'h3000, 16'h0);
        run(3);
        reset_mid();
        run(10);
        post(0, 1'b0, 16'h0010, 16'h0);
        run(10);

        // randomized traffic, then a reset, then more traffic and a drain
        rand_mode = 1'b1;
        run(1200);
        reset_mid();
        run(600);
        rand_mode = 1'b0;
        run(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
